// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered ALU between two valid/ready requesters.
// Each operation runs IDLE -> ISSUE -> CAPTURE -> RESP: latch, enable, capture, return.
module alu_arbiter #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [5:0]             req_op,
  input  logic [2*WORD_SIZE-1:0] req_a,
  input  logic [2*WORD_SIZE-1:0] req_b,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [WORD_SIZE-1:0]   rsp_data,
  output logic [2:0]             alu_op,
  output logic [WORD_SIZE-1:0]   alu_in1,
  output logic [WORD_SIZE-1:0]   alu_in2,
  output logic                   alu_enable,
  input  logic [WORD_SIZE-1:0]   alu_out,
  output logic                   busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StCapture, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic [2:0]             alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0]   alu_in1_q, alu_in1_d;
  logic [WORD_SIZE-1:0]   alu_in2_q, alu_in2_d;
  logic [WORD_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic                   grant;

  always_comb begin
    grant        = 1'b0;
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    alu_op_d     = alu_op_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    rsp_data_d   = rsp_data_q;
    req_ready    = 2'b00;
    rsp_valid    = 2'b00;
    alu_enable   = 1'b0;

    // On a tie the requester that did not win last time goes next.
    unique case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant_q;
      default: grant = 1'b0;
    endcase

    unique case (state_q)
      StIdle: begin
        // Gate with reset_n so ready stays low while reset is held.
        if (reset_n && (req_valid != 2'b00)) begin
          req_ready    = grant ? 2'b10 : 2'b01;
          state_d      = StIssue;
          owner_d      = grant;
          last_grant_d = grant;
          alu_op_d     = grant ? req_op[5:3] : req_op[2:0];
          alu_in1_d    = grant ? req_a[2*WORD_SIZE-1:WORD_SIZE] : req_a[WORD_SIZE-1:0];
          alu_in2_d    = grant ? req_b[2*WORD_SIZE-1:WORD_SIZE] : req_b[WORD_SIZE-1:0];
        end
      end
      StIssue: begin
        alu_enable = 1'b1;
        state_d    = StCapture;
      end
      StCapture: begin
        rsp_data_d = alu_out;
        state_d    = StResp;
      end
      StResp: begin
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        if (rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      alu_op_q     <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      alu_op_q     <= alu_op_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign alu_op   = alu_op_q;
  assign alu_in1  = alu_in1_q;
  assign alu_in2  = alu_in2_q;
  assign rsp_data = rsp_data_q;
  assign busy     = (state_q != StIdle);

endmodule
